armleosoc_axi_write_arbiter: RTL

- Shares one AXI4 write channel (AW/W/B) between OPT_NUMBER_OF_HOSTS upstream hosts (CPU, DMA, debug); the downstream side feeds the SoC write router.
- Round-robin arbitration on AW requests.
- A grant is held for one complete transaction: AW handshake, W burst through WLAST, then B handshake.
- One outstanding write at a time; no reordering, so downstream BID is returned unchanged.

---
 rtl/armleosoc_axi_pkg.sv | 21 ++
 rtl/armleosoc_rr_arbiter.sv | 31 +++
 rtl/armleosoc_axi_write_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/armleosoc_axi_pkg.sv
// Shared AXI definitions for the armleosoc interconnect blocks:
// arbiter state encoding, AXI response codes and AXI burst encodings.
package armleosoc_axi_pkg;

   // Arbiter FSM: IDLE waits for a request, ACTIVE owns the channel
   // until the B handshake of the granted transaction.
   typedef enum logic [0:0] {
      STATE_IDLE   = 1'b0,
      STATE_ACTIVE = 1'b1
   } arb_state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

endpackage

// File: rtl/armleosoc_rr_arbiter.sv
// Combinational rotating-priority picker: returns the first requester
// found scanning ptr, ptr+1, ... (mod N). Shared by the read and write
// arbiters; a ptr tied to zero turns it into a fixed-priority picker.
module armleosoc_rr_arbiter
   import armleosoc_axi_pkg::*;
#(
   parameter int N = 2,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] grant,
   output logic         any_req
);

   // Scan from ptr with wrap-around; the first hit wins.
   always_comb begin : scan
      logic [W-1:0] idx;
      idx     = '0;
      grant   = '0;
      any_req = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = W'((int'(ptr) + k) % N);
         if (!any_req && req[idx]) begin
            any_req = 1'b1;
            grant   = idx;
         end
      end
   end

endmodule

// File: rtl/armleosoc_axi_write_arbiter.sv
// AXI4 write-channel arbiter: shares one downstream AW/W/B channel between
// OPT_NUMBER_OF_HOSTS upstream hosts, one outstanding write at a time.
// A grant covers AW handshake, W burst through WLAST, and the B handshake.
// Build option: define ARMLEOSOC_AXI_WRITE_ARBITER_FIXED_PRIORITY_EN to make
// the lowest-index requester always win (no round-robin pointer).
//
// Handshake rule used on every channel here: a transfer happens in the cycle
// where valid and ready are both high; valid never waits on ready, and while
// the arbiter is IDLE no valid or ready is driven on either side.
module armleosoc_axi_write_arbiter
   import armleosoc_axi_pkg::*;
#(
   parameter int ADDR_WIDTH          = 34,
   parameter int ID_WIDTH            = 4,
   parameter int DATA_WIDTH          = 32,
   parameter int OPT_NUMBER_OF_HOSTS = 2
) (
   input  logic                                       clk,
   input  logic                                       rst_n,

   input  logic [OPT_NUMBER_OF_HOSTS-1:0]             upstream_axi_awvalid,
   output logic [OPT_NUMBER_OF_HOSTS-1:0]             upstream_axi_awready,
   input  logic [OPT_NUMBER_OF_HOSTS*ADDR_WIDTH-1:0]  upstream_axi_awaddr,
   input  logic [OPT_NUMBER_OF_HOSTS*8-1:0]           upstream_axi_awlen,
   input  logic [OPT_NUMBER_OF_HOSTS*3-1:0]           upstream_axi_awsize,
   input  logic [OPT_NUMBER_OF_HOSTS*2-1:0]           upstream_axi_awburst,
   input  logic [OPT_NUMBER_OF_HOSTS-1:0]             upstream_axi_awlock,
   input  logic [OPT_NUMBER_OF_HOSTS*3-1:0]           upstream_axi_awprot,
   input  logic [OPT_NUMBER_OF_HOSTS*ID_WIDTH-1:0]    upstream_axi_awid,

   input  logic [OPT_NUMBER_OF_HOSTS-1:0]             upstream_axi_wvalid,
   output logic [OPT_NUMBER_OF_HOSTS-1:0]             upstream_axi_wready,
   input  logic [OPT_NUMBER_OF_HOSTS*DATA_WIDTH-1:0]  upstream_axi_wdata,
   input  logic [OPT_NUMBER_OF_HOSTS*(DATA_WIDTH/8)-1:0] upstream_axi_wstrb,
   input  logic [OPT_NUMBER_OF_HOSTS-1:0]             upstream_axi_wlast,

   output logic [OPT_NUMBER_OF_HOSTS-1:0]             upstream_axi_bvalid,
   input  logic [OPT_NUMBER_OF_HOSTS-1:0]             upstream_axi_bready,
   output logic [1:0]                                 upstream_axi_bresp,
   output logic [ID_WIDTH-1:0]                        upstream_axi_bid,

   output logic                                       downstream_axi_awvalid,
   input  logic                                       downstream_axi_awready,
   output logic [ADDR_WIDTH-1:0]                      downstream_axi_awaddr,
   output logic [7:0]                                 downstream_axi_awlen,
   output logic [2:0]                                 downstream_axi_awsize,
   output logic [1:0]                                 downstream_axi_awburst,
   output logic                                       downstream_axi_awlock,
   output logic [2:0]                                 downstream_axi_awprot,
   output logic [ID_WIDTH-1:0]                        downstream_axi_awid,

   output logic                                       downstream_axi_wvalid,
   input  logic                                       downstream_axi_wready,
   output logic [DATA_WIDTH-1:0]                      downstream_axi_wdata,
   output logic [(DATA_WIDTH/8)-1:0]                  downstream_axi_wstrb,
   output logic                                       downstream_axi_wlast,

   input  logic                                       downstream_axi_bvalid,
   output logic                                       downstream_axi_bready,
   input  logic [1:0]                                 downstream_axi_bresp,
   input  logic [ID_WIDTH-1:0]                        downstream_axi_bid
);

   localparam int DATA_STROBES = DATA_WIDTH / 8;
   localparam int N            = OPT_NUMBER_OF_HOSTS;
   localparam int HOST_CLOG2   = $clog2(OPT_NUMBER_OF_HOSTS);

   arb_state_t              state_q,  state_d;
   logic [HOST_CLOG2-1:0]   grant_q,  grant_d;
   logic                    awdone_q, awdone_d;
   logic                    wdone_q,  wdone_d;

   logic [HOST_CLOG2-1:0]   arb_ptr;
   logic [HOST_CLOG2-1:0]   arb_grant;
   logic                    arb_any;

`ifdef ARMLEOSOC_AXI_WRITE_ARBITER_FIXED_PRIORITY_EN
   // Scanning always starts at host 0, so the lowest index wins.
   assign arb_ptr = '0;
`else
   logic [HOST_CLOG2-1:0]   rr_ptr_q, rr_ptr_d;
   assign arb_ptr = rr_ptr_q;
`endif

   armleosoc_rr_arbiter #(
      .N (N),
      .W (HOST_CLOG2)
   ) u_rr_arbiter (
      .req     (upstream_axi_awvalid),
      .ptr     (arb_ptr),
      .grant   (arb_grant),
      .any_req (arb_any)
   );

   // State register: everything clears at once when rst_n drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= STATE_IDLE;
         grant_q  <= '0;
         awdone_q <= 1'b0;
         wdone_q  <= 1'b0;
`ifndef ARMLEOSOC_AXI_WRITE_ARBITER_FIXED_PRIORITY_EN
         rr_ptr_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         awdone_q <= awdone_d;
         wdone_q  <= wdone_d;
`ifndef ARMLEOSOC_AXI_WRITE_ARBITER_FIXED_PRIORITY_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end

   // Next state: grant in IDLE, track AW/W completion, release on B.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      awdone_d = awdone_q;
      wdone_d  = wdone_q;
`ifndef ARMLEOSOC_AXI_WRITE_ARBITER_FIXED_PRIORITY_EN
      rr_ptr_d = rr_ptr_q;
`endif
      case (state_q)
         STATE_IDLE: begin
            if (arb_any) begin
               state_d  = STATE_ACTIVE;
               grant_d  = arb_grant;
               awdone_d = 1'b0;
               wdone_d  = 1'b0;
            end
         end
         STATE_ACTIVE: begin
            if (downstream_axi_awvalid && downstream_axi_awready)
               awdone_d = 1'b1;
            if (downstream_axi_wvalid && downstream_axi_wready && downstream_axi_wlast)
               wdone_d = 1'b1;
            if (downstream_axi_bvalid && downstream_axi_bready) begin
               state_d  = STATE_IDLE;
               awdone_d = 1'b0;
               wdone_d  = 1'b0;
`ifndef ARMLEOSOC_AXI_WRITE_ARBITER_FIXED_PRIORITY_EN
               rr_ptr_d = (grant_q == HOST_CLOG2'(N - 1)) ? '0 : grant_q + 1'b1;
`endif
            end
         end
         default: state_d = STATE_IDLE;
      endcase
   end

   // Outputs: payload muxed from the granted slice; handshakes gated by
   // state and the done flags so each channel transfers exactly once.
   always_comb begin
      upstream_axi_awready   = '0;
      upstream_axi_wready    = '0;
      upstream_axi_bvalid    = '0;
      downstream_axi_awvalid = 1'b0;
      downstream_axi_wvalid  = 1'b0;
      downstream_axi_bready  = 1'b0;

      downstream_axi_awaddr  = '0;
      downstream_axi_awlen   = '0;
      downstream_axi_awsize  = '0;
      downstream_axi_awburst = '0;
      downstream_axi_awlock  = 1'b0;
      downstream_axi_awprot  = '0;
      downstream_axi_awid    = '0;
      downstream_axi_wdata   = '0;
      downstream_axi_wstrb   = '0;
      downstream_axi_wlast   = upstream_axi_wlast[grant_q];
      for (int h = 0; h < N; h++) begin
         if (grant_q == HOST_CLOG2'(h)) begin
            downstream_axi_awaddr  = upstream_axi_awaddr[h*ADDR_WIDTH +: ADDR_WIDTH];
            downstream_axi_awlen   = upstream_axi_awlen[h*8 +: 8];
            downstream_axi_awsize  = upstream_axi_awsize[h*3 +: 3];
            downstream_axi_awburst = upstream_axi_awburst[h*2 +: 2];
            downstream_axi_awlock  = upstream_axi_awlock[h];
            downstream_axi_awprot  = upstream_axi_awprot[h*3 +: 3];
            downstream_axi_awid    = upstream_axi_awid[h*ID_WIDTH +: ID_WIDTH];
            downstream_axi_wdata   = upstream_axi_wdata[h*DATA_WIDTH +: DATA_WIDTH];
            downstream_axi_wstrb   = upstream_axi_wstrb[h*DATA_STROBES +: DATA_STROBES];
         end
      end

      if (state_q == STATE_ACTIVE) begin
         downstream_axi_awvalid        = upstream_axi_awvalid[grant_q] && !awdone_q;
         upstream_axi_awready[grant_q] = downstream_axi_awready && !awdone_q;
         downstream_axi_wvalid         = upstream_axi_wvalid[grant_q] && !wdone_q;
         upstream_axi_wready[grant_q]  = downstream_axi_wready && !wdone_q;
         if (awdone_q && wdone_q) begin
            upstream_axi_bvalid[grant_q] = downstream_axi_bvalid;
            downstream_axi_bready        = upstream_axi_bready[grant_q];
         end
      end
   end

   // Write response travels back unchanged; only bvalid is steered.
   assign upstream_axi_bresp = downstream_axi_bresp;
   assign upstream_axi_bid   = downstream_axi_bid;

endmodule
